// File: rtl/rst_seq_sync.sv
// rst_seq_sync: merges async + software reset requests, releases domains in order.
// Optional macro RST_SEQ_CAUSE_EN adds sticky reset-cause capture (cause_clr/rst_cause).
module rst_seq_sync #(
    parameter int NUM_STAGES    = 3,
    parameter int NUM_SRC       = 2,
    parameter int NUM_DOMAINS   = 4,
    parameter int FILTER_CYCLES = 4,
    parameter int GAP_CYCLES    = 8
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [NUM_SRC-1:0]     rst_req_n,
    input  logic                   sw_rst_req,
`ifdef RST_SEQ_CAUSE_EN
    input  logic                   cause_clr,
    output logic [NUM_SRC:0]       rst_cause,
`endif
    output logic [NUM_DOMAINS-1:0] Sync_RST_n,
    output logic                   seq_done,
    output logic [1:0]             seq_state
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  =
        IW'((NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [NUM_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0]                 req_s;
    logic                               req_c;

    logic [1:0]             state_q, state_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   done_q, done_d;

    // Stage 0 takes the raw input; the last stage is the synchronised request.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], rst_req_n};
        end
    end

    assign req_s = sync_q[NUM_STAGES-1];
    assign req_c = (~&req_s) | sw_rst_req;

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        if (req_c) begin
            // A new request always pulls every domain back into reset at once.
            state_d = S_HOLD;
            filt_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    if (filt_q == FILT_LAST) begin
                        filt_d     = '0;
                        gap_d      = '0;
                        idx_d      = '0;
                        rst_n_d[0] = 1'b1;
                        if (NUM_DOMAINS == 1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int k = 1; k < NUM_DOMAINS; k++) begin
                            if (idx_q == IW'(k - 1)) begin
                                rst_n_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_HOLD;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_HOLD;
            filt_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
        end
    end

    assign Sync_RST_n = rst_n_q;
    assign seq_done   = done_q;
    assign seq_state  = state_q;

`ifdef RST_SEQ_CAUSE_EN
    logic [NUM_SRC:0] cause_q, cause_d, cause_set;

    // New causes win over a same-edge clear so no request is lost.
    always_comb begin
        cause_set = {sw_rst_req, ~req_s};
        cause_d   = (cause_clr ? '0 : cause_q) | cause_set;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cause_q <= '0;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: directed vector table, then random traffic vs a run-length model.
// Cause-capture checks are compiled only when RST_SEQ_CAUSE_EN is defined.
module tb_rst_seq_sync;

    localparam int NS   = 3;
    localparam int NSRC = 2;
    localparam int ND   = 4;
    localparam int F    = 4;
    localparam int G    = 8;

    logic            clk = 1'b0;
    logic            RST;
    logic [NSRC-1:0] rst_req_n;
    logic            sw_rst_req;
    logic [ND-1:0]   Sync_RST_n;
    logic            seq_done;
    logic [1:0]      seq_state;
`ifdef RST_SEQ_CAUSE_EN
    logic            cause_clr;
    logic [NSRC:0]   rst_cause;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [NSRC-1:0] hist[$];
    int              run = 0;

    typedef struct {
        logic            r;
        logic [NSRC-1:0] rq;
        logic            s;
        int              n;
        logic [ND-1:0]   rn;
        logic            d;
        logic [1:0]      st;
    } vec_t;

    vec_t vt[$];

    rst_seq_sync #(
        .NUM_STAGES   (NS),
        .NUM_SRC      (NSRC),
        .NUM_DOMAINS  (ND),
        .FILTER_CYCLES(F),
        .GAP_CYCLES   (G)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .rst_req_n (rst_req_n),
        .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_CAUSE_EN
        .cause_clr (cause_clr),
        .rst_cause (rst_cause),
`endif
        .Sync_RST_n(Sync_RST_n),
        .seq_done  (seq_done),
        .seq_state (seq_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: released domains follow from the length of the current clean run.
    function automatic void model_edge(input logic r, input logic [NSRC-1:0] rq,
                                       input logic s);
        logic reqc;
        if (r) begin
            hist.delete();
            for (int i = 0; i < NS; i++) hist.push_back('0);
            run = 0;
        end else begin
            reqc = (hist[0] != {NSRC{1'b1}}) || s;
            if (reqc) run = 0;
            else if (run < 100000) run = run + 1;
            void'(hist.pop_front());
            hist.push_back(rq);
        end
    endfunction

    function automatic logic [31:0] model_out();
        int            rel;
        logic [ND-1:0] rn;
        logic [1:0]    st;
        if (run < F) rel = 0;
        else rel = 1 + (run - F) / G;
        if (rel > ND) rel = ND;
        rn = ND'((1 << rel) - 1);
        st = (rel == 0) ? 2'd0 : (rel == ND) ? 2'd2 : 2'd1;
        return 32'({rn, (rel == ND), st});
    endfunction

    task automatic step(input logic r, input logic [NSRC-1:0] rq, input logic s);
        RST        = r;
        rst_req_n  = rq;
        sw_rst_req = s;
        @(posedge clk);
        model_edge(r, rq, s);
        #1;
    endtask

    function automatic void add(input logic r, input logic [NSRC-1:0] rq,
                                input logic s, input int n, input logic [ND-1:0] rn,
                                input logic d, input logic [1:0] st);
        vec_t v;
        v.r = r; v.rq = rq; v.s = s; v.n = n;
        v.rn = rn; v.d = d; v.st = st;
        vt.push_back(v);
    endfunction

    initial begin
        logic            r_v;
        logic [NSRC-1:0] rq_v;
        logic            s_v;

        RST        = 1'b1;
        rst_req_n  = '1;
        sw_rst_req = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
        cause_clr  = 1'b0;
`endif

        // Power-up release schedule: 7, 15, 23, 31.
        add(1, 2'b11, 0, 3, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 6, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0011, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0011, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0111, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0111, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b1111, 1, 2'd2);
        add(0, 2'b11, 0, 5, 4'b1111, 1, 2'd2);
        // sw pulse, then a dip on source 1 two edges later.
        add(0, 2'b11, 1, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b01, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 3, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0011, 0, 2'd1);
        // Abort from 0011 via source 0: lands 4 edges after sampling.
        add(0, 2'b10, 0, 1, 4'b0011, 0, 2'd1);
        add(0, 2'b11, 0, 2, 4'b0011, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 3, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0011, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0011, 0, 2'd1);
        // sw request on the domain-2 release edge.
        add(0, 2'b11, 1, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 3, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 3, 4'b0001, 0, 2'd1);
        // RST during RELEASE restarts the whole schedule.
        add(1, 2'b11, 0, 1, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 6, 4'b0000, 0, 2'd0);
        add(0, 2'b11, 0, 1, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 7, 4'b0001, 0, 2'd1);
        add(0, 2'b11, 0, 1, 4'b0011, 0, 2'd1);

        foreach (vt[i]) begin
            for (int c = 0; c < vt[i].n; c++) begin
                step(vt[i].r, vt[i].rq, vt[i].s);
                check($sformatf("vec%0d.%0d", i, c),
                      32'({Sync_RST_n, seq_done, seq_state}),
                      32'({vt[i].rn, vt[i].d, vt[i].st}));
            end
        end

`ifdef RST_SEQ_CAUSE_EN
        cause_clr = 1'b1;
        step(0, 2'b11, 0);
        check("cause_clr0", 32'(rst_cause), 32'd0);
        cause_clr = 1'b0;
        step(0, 2'b01, 0);
        check("cause_dip", 32'(rst_cause), 32'd0);
        step(0, 2'b11, 0);
        step(0, 2'b11, 0);
        check("cause_sync", 32'(rst_cause), 32'd0);
        step(0, 2'b11, 0);
        check("cause_src1", 32'(rst_cause), 32'b010);
        step(0, 2'b11, 1);
        check("cause_sw", 32'(rst_cause), 32'b110);
        step(0, 2'b11, 0);
        check("cause_sticky", 32'(rst_cause), 32'b110);
        cause_clr = 1'b1;
        step(0, 2'b11, 0);
        check("cause_clr", 32'(rst_cause), 32'd0);
        step(0, 2'b11, 1);
        check("cause_set_win", 32'(rst_cause), 32'b100);
        cause_clr = 1'b0;
`endif

        for (int c = 0; c < 4000; c++) begin
            r_v  = ($urandom_range(0, 499) == 0);
            rq_v = '1;
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(0, 149) == 0) rq_v[b] = 1'b0;
            end
            s_v = ($urandom_range(0, 199) == 0);
            step(r_v, rq_v, s_v);
            check($sformatf("rand%0d", c),
                  32'({Sync_RST_n, seq_done, seq_state}), model_out());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rst_seq_sync.md
Name: rst_seq_sync

Overview:
Parametrised reset synchroniser and sequencer.
- Merges NUM_SRC external asynchronous active-low reset requests with one synchronous software request.
- Synchronises each external request through a NUM_STAGES flop chain.
- Drives NUM_DOMAINS active-low domain resets. All domains assert together; they release one at a time in index order, after a glitch filter.
- Sits at the top of each clock region and replaces the single-output reset synchroniser.

Parameters:
NUM_STAGES, 3, synchroniser depth per external request (>=2)
NUM_SRC, 2, number of asynchronous external reset request inputs (>=1)
NUM_DOMAINS, 4, number of sequenced reset outputs (>=1)
FILTER_CYCLES, 4, consecutive clean request-free samples required before the first release (>=1)
GAP_CYCLES, 8, clock edges between release of domain k-1 and domain k (>=1)

Ports:
clk  input  1  block clock
RST  input  1  block reset, synchronous, active-high
rst_req_n  input  NUM_SRC  asynchronous reset requests, active-low; each pulse must be held low >= 1 clk period
sw_rst_req  input  1  synchronous software reset request, active-high, sampled directly (not synchronised)
Sync_RST_n  output  NUM_DOMAINS  sequenced domain resets, active-low (0 = domain held in reset)
seq_done  output  1  high once all domains are released
seq_state  output  2  current FSM state encoding: 0 HOLD, 1 RELEASE, 2 DONE

Behaviour:
- Reset and clocking: one clock (clk). RST is synchronous and active-high.
- While RST=1, at every edge:
  - all synchroniser flops <= 0 (request asserted)
  - Sync_RST_n <= all 0; seq_done <= 0
  - state <= HOLD; filter and gap counters <= 0; domain index <= 0
- Synchroniser: each rst_req_n bit passes through NUM_STAGES flops, giving req_s[i].
- Combined request: req_c = (any req_s[i]==0) | sw_rst_req.
- A "clean sample" is an edge where req_c=0.
- Counter widths: filter counter is $clog2(FILTER_CYCLES+1); gap counter is $clog2(GAP_CYCLES+1); index is max(1,$clog2(NUM_DOMAINS)).
- Counters never wrap: each is cleared on its terminal compare.
- HOLD state:
  - Sync_RST_n all 0, seq_done 0.
  - req_c=1: filter counter <= 0.
  - Clean sample with filter counter < FILTER_CYCLES-1: increment.
  - Clean sample with filter counter == FILTER_CYCLES-1: on that same edge, Sync_RST_n[0] <= 1, gap counter <= 0, index <= 0.
    - NUM_DOMAINS==1: go to DONE and set seq_done <= 1.
    - Otherwise: go to RELEASE.
- RELEASE state:
  - Clean sample with gap counter < GAP_CYCLES-1: increment.
  - Clean sample with gap counter == GAP_CYCLES-1: Sync_RST_n[index+1] <= 1, index++, gap counter <= 0.
  - When that release is of the last domain: on the same edge, seq_done <= 1 and state <= DONE.
- DONE state: outputs hold; seq_done = 1.
- Abort (RELEASE or DONE): req_c=1 on any edge gives, on that edge, Sync_RST_n <= all 0, seq_done <= 0, state <= HOLD, all counters <= 0.
  - Released domains are never left partially out of reset once a new request arrives.
- Latency to assertion:
  - rst_req_n falling, stable before an edge: Sync_RST_n all 0 after NUM_STAGES+1 edges.
  - sw_rst_req: Sync_RST_n all 0 after 1 edge.
- Release timing, with edges counted from the first edge with RST=0 and inputs idle:
  - domain k releases at edge NUM_STAGES + FILTER_CYCLES + k*GAP_CYCLES.
  - Defaults: edges 7, 15, 23, 31; seq_done at edge 31.
- Release order: Sync_RST_n bits only ever rise in ascending index order and never more than one per edge.
- Simultaneous events:
  - RST has priority over everything.
  - A request on the same edge as a scheduled release wins: no release occurs and state goes to HOLD.

Optional Feature:
Macro: RST_SEQ_CAUSE_EN.
- Defined: adds input cause_clr (1, active-high, synchronous) and output rst_cause (NUM_SRC+1 bits).
  - Bit i (i < NUM_SRC) sets when req_s[i]==0; bit NUM_SRC sets when sw_rst_req==1.
  - Bits are sticky until cause_clr=1; setting has priority over cause_clr on the same edge.
  - RST sets rst_cause <= 0.
- Undefined: neither port exists; no cause logic is present.

Test Plan:
- Power-up, defaults, inputs idle: RST=1 for 3 edges, then 0 -> Sync_RST_n=4'b0000 until edge 6; then 4'b0001 @7, 4'b0011 @15, 4'b0111 @23, 4'b1111 @31; seq_done=1 @31, seq_state=2.
- Filter glitch: from DONE, sw_rst_req=1 for 1 cycle, then rst_req_n[1]=0 for 1 cycle 2 edges after the sw pulse -> Sync_RST_n=0 after 1 edge. Filter restarts on the rst_req_n[1] dip; first release 3+4 edges after the dip was sampled.
- Abort mid-sequence: rst_req_n[0]=0 while Sync_RST_n=4'b0011 -> 4 edges later Sync_RST_n=4'b0000, seq_state=0, seq_done=0; no bit rises during the abort.
- Collision: sw_rst_req=1 on the exact edge scheduled for domain 2 release -> Sync_RST_n goes 4'b0011 -> 4'b0000, never 4'b0111.
- Reset mid-operation: RST=1 in RELEASE -> next edge all outputs 0, counters 0; sequence restarts from edge count 0 after RST drops.
- Cause capture, RST_SEQ_CAUSE_EN defined: pulse rst_req_n[1], then sw_rst_req -> rst_cause=3'b110; cause_clr=1 -> 3'b000.
